// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage divider.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

  localparam int DIV_CYCLES   = 32;
  localparam int DIV_RESULT_W = 64;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}
// so the upper half feeds HI and the lower half feeds LO.
module div_unit #(
  parameter int DIV_CYCLES = cpu_pkg::DIV_CYCLES
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              signed_div_i,
  input  logic [31:0]                       opdata1_i,
  input  logic [31:0]                       opdata2_i,
  input  logic                              annul_i,
  output logic [cpu_pkg::DIV_RESULT_W-1:0]  result_o,
  output logic                              ready_o,
  output logic                              busy_o
);
  import cpu_pkg::*;

  localparam int               CNT_W     = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

  div_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [64:0]       work_reg, work_next;
  logic [31:0]       divisor_reg, divisor_next;
  logic              neg_quot_reg, neg_quot_next;
  logic              neg_rem_reg, neg_rem_next;
  logic [63:0]       result_reg, result_next;

  logic [33:0]       trial;
  logic [64:0]       work_step;
  logic [31:0]       quot_fixed, rem_fixed;
  logic [31:0]       abs_dividend, abs_divisor;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    work_next     = work_reg;
    divisor_next  = divisor_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    busy_o        = 1'b0;
    ready_o       = 1'b0;

    // Trial subtract on the shifted remainder; including bit 64 keeps the
    // compare exact for the full 34-bit shifted value.
    trial     = work_reg[64:31] - {2'b00, divisor_reg};
    work_step = trial[33] ? {work_reg[63:0], 1'b0}
                          : {trial[32:0], work_reg[30:0], 1'b1};
    quot_fixed = neg_quot_reg ? -work_step[31:0]  : work_step[31:0];
    rem_fixed  = neg_rem_reg  ? -work_step[63:32] : work_step[63:32];

    abs_dividend = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    abs_divisor  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    unique case (state_reg)
      IDLE: begin
        if (start_i && !annul_i) begin
          busy_o        = 1'b1;
          state_next    = (opdata2_i == 32'd0) ? BY_ZERO : ON;
          cnt_next      = '0;
          work_next     = {33'd0, abs_dividend};
          divisor_next  = abs_divisor;
          neg_quot_next = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_next  = signed_div_i && opdata1_i[31];
        end
      end
      BY_ZERO: begin
        busy_o = 1'b1;
        if (annul_i) begin
          state_next = IDLE;
        end else begin
          result_next = '0;
          state_next  = END;
        end
      end
      ON: begin
        busy_o = 1'b1;
        if (annul_i) begin
          state_next = IDLE;
        end else begin
          work_next = work_step;
          cnt_next  = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_ITER) begin
            result_next = {rem_fixed, quot_fixed};
            state_next  = END;
          end
        end
      end
      END: begin
        ready_o    = !annul_i;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      divisor_reg  <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      work_reg     <= work_next;
      divisor_reg  <= divisor_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
    end
  end

  assign result_o = result_reg;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for DIV/DIVU in the EX stage, directly upstream of MEM. It latches two 32-bit operands on a start request, computes quotient and remainder in 32 iterations, and presents a 64-bit {remainder, quotient} word. The EX stage forwards that word as the double-width write data whose upper half lands in HI and lower half in LO. EX holds the pipeline on `busy_o` and drops the operation on `annul_i` when MEM flushes for an exception.

## Interface
Parameters:
- `DIV_CYCLES`, 32: iteration count; equals operand width, not to be overridden.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  request a divide; sampled only in IDLE.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU; latched with operands.
- `opdata1_i`  in  32  dividend; latched when start is accepted.
- `opdata2_i`  in  32  divisor; latched when start is accepted.
- `annul_i`  in  1  flush; cancels any in-flight divide.
- `result_o`  out  64  [63:32] remainder (HI), [31:0] quotient (LO); registered.
- `ready_o`  out  1  result valid; one-cycle pulse.
- `busy_o`  out  1  divide in progress; EX raises stall while high.

## Operation
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - `start_i & ~annul_i` with divisor 0 → BY_ZERO.
  - `start_i & ~annul_i` with divisor ≠ 0 → ON, iteration counter = 0.
  - Operands and sign mode latch on the same edge.
- Operand conditioning when signed: dividend and divisor replaced by their absolute values. |0x80000000| = 0x80000000 as unsigned.
- ON, restoring division:
  - 65-bit working register {partial remainder 33b, dividend 32b}.
  - Each cycle: shift left 1; trial subtract the divisor from the upper 33 bits; if no borrow, keep the difference and set the LSB (quotient bit) to 1.
  - Counter increments each cycle. After iteration index 31 → END.
- Sign fix-up on the END transition (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Arithmetic is 32-bit modulo, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- BY_ZERO: `result_o` loads 0 → END. Both HI and LO become zero.
- END: `ready_o` = 1 for this cycle only → IDLE next edge.
- `result_o` holds its value until the next completed divide or reset.
- `annul_i` in BY_ZERO or ON → IDLE next edge. `ready_o` is not asserted and `result_o` is unchanged.
- `annul_i` in END: `ready_o` is suppressed that cycle; still → IDLE.
- `annul_i` has priority over `start_i` in the same cycle.
- `start_i` outside IDLE is ignored. It is not queued.
- `busy_o` = (state ∈ {BY_ZERO, ON}) | (IDLE & `start_i` & ~`annul_i`). This lets EX stall in the request cycle itself.

## Timing
- On reset assertion, asynchronously: state = IDLE, counter = 0, working register = 0, `result_o` = 0, `ready_o` = 0. `busy_o` = 0 unless `start_i` is high.
- Start accepted at edge t (IDLE):
  - Nonzero divisor: ON occupies cycles t+1..t+32; END and `ready_o` in cycle t+33. Latency is 33 cycles.
  - Zero divisor: BY_ZERO in cycle t+1; `ready_o` in cycle t+2.
- Earliest restart: `start_i` in the cycle after END (IDLE). No back-to-back acceptance in the END cycle.
- Reset mid-operation aborts immediately. No pulse follows release.

## Structure
- Shared package `cpu_pkg` holds:
  - `div_state_t` enum {IDLE, BY_ZERO, ON, END};
  - `DIV_CYCLES` = 32;
  - `DIV_RESULT_W` = 64.
- No sub-module. The 33-bit trial subtractor is an inline combinational expression. FSM, counter and datapath live in one always_ff plus one always_comb.

## Test plan
- DIVU 100 / 7, start at edge 0 → `ready_o` only in cycle 33; `result_o` = 0x00000002_0000000E.
- DIV −7 (0xFFFFFFF9) / 2 → `result_o` = 0xFFFFFFFF_FFFFFFFD (rem −1, quot −3). Also 7 / −2 → 0x00000001_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Divisor 0 (any dividend, both modes) → `busy_o` high cycles 0–1, `ready_o` in cycle 2, `result_o` = 0.
- Sequence: DIVU 50/5 completes; DIV 9/4 starts, `annul_i` at iteration 10 → `busy_o` drops next cycle, no `ready_o`, `result_o` stays 0x00000000_0000000A. A new DIVU 9/4 then yields 0x00000001_00000002 after 33 cycles. `start_i` pulses while busy have no effect.
- Assert `rst_i` asynchronously mid-ON (between edges) → `result_o`, `ready_o`, `busy_o` go 0 immediately. After release, no spurious `ready_o` in 40 idle cycles.
